recv_exceed_abs_pack: RTL and testbench
=======================================

Name: recv_exceed_abs_pack

Overview:
- Consumer side of the exceed-map interface produced by the delta threshold/abs stage.
- Captures one frame per `frame_valid_i` strobe: a 16-bit exceed map plus two 16-entry unsigned |delta| arrays.
- Walks the flagged indices in ascending order and emits only flagged entries as packets on a valid/ready stream, for downstream fault-map/correction logic.
- Reports per-frame count, last-packet marker and frame completion.

Parameters:
- INWIDTH_DELTA, 17, width of each unsigned |delta| entry.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- frame_valid_i  in  1  one-cycle strobe; map and arrays valid this cycle
- exceed_map_i  in  16  bit k=1 -> entry k exceeded both thresholds
- delta1_abs_i  in  16 x INWIDTH_DELTA  unsigned |delta1| per index
- delta2_abs_i  in  16 x INWIDTH_DELTA  unsigned |delta2| per index
- pkt_ready_i  in  1  downstream accepts packet
- pkt_valid_o  out  1  packet valid
- pkt_idx_o  out  4  index of emitted entry
- pkt_delta1_o  out  INWIDTH_DELTA  |delta1| at pkt_idx_o
- pkt_delta2_o  out  INWIDTH_DELTA  |delta2| at pkt_idx_o
- pkt_last_o  out  1  packet is highest set bit of frame
- exceed_cnt_o  out  5  popcount of captured map (0..16)
- busy_o  out  1  high whenever state != IDLE
- frame_done_o  out  1  high for the single DONE cycle
- frame_drop_o  out  1  one-cycle pulse: strobe arrived while busy

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; idx, map_r and both array registers cleared.
  - All outputs 0.
  - A pending packet is discarded. No partial frame survives reset.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - Condition to capture: frame_valid_i=1.
  - On capture, register map_r, both arrays, and exceed_cnt_o = popcount(exceed_map_i). Set idx=0.
  - If exceed_map_i==0 -> DONE; else -> SCAN.
- SCAN (one index per cycle):
  - If map_r[idx]=0: idx<=idx+1 and stay in SCAN. idx==15 is unreachable with bit 0, since a set bit remains.
  - If map_r[idx]=1: register the packet and go to EMIT.
    - pkt_idx_o=idx; pkt_delta1_o, pkt_delta2_o from array[idx].
    - pkt_last_o = (map_r with bits 0..idx cleared)==0.
    - pkt_valid_o<=1.
- EMIT:
  - Packet fields are held stable while pkt_valid_o=1 and pkt_ready_i=0. No timeout.
  - Accept occurs on an edge with pkt_valid_o=1 and pkt_ready_i=1. On accept, pkt_valid_o<=0 and map_r[idx]<=0.
  - After accept: if pkt_last_o -> DONE; else idx<=idx+1 and -> SCAN.
- DONE:
  - frame_done_o=1 for one cycle, then -> IDLE. exceed_cnt_o is held until the next capture.
- pkt_valid_o never asserts in IDLE, SCAN or DONE.
  - The cycle after an accept always has pkt_valid_o=0, so back-to-back packets are at most one every 2 cycles.
- Latency:
  - Capture edge to first pkt_valid_o = (first set index) + 2 cycles.
  - Empty map: frame_done_o one cycle after capture.
- frame_valid_i in any state other than IDLE:
  - The strobe is ignored; captured data is untouched.
  - frame_drop_o pulses on the next cycle.
  - frame_valid_i in the DONE cycle is also dropped.
- Map 0xFFFF: 16 packets, idx 0..15 in order. pkt_last_o on idx 15; exceed_cnt_o=16.
- Arithmetic: no sign handling; inputs are already unsigned magnitudes and are passed through unmodified.

Optional Feature:
- Macro: RECV_EXCEED_SUM_EN.
- Defined:
  - Adds output sum_delta1_o, width INWIDTH_DELTA+4, reset 0.
  - Cleared to 0 on capture.
  - Adds pkt_delta1_o on each accept.
  - Holds its value through DONE and until the next capture; valid when frame_done_o=1.
  - Never overflows (16 x max fits).
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Empty frame: map=0x0000 -> no pkt_valid_o, exceed_cnt_o=0, frame_done_o high exactly 1 cycle after capture edge, busy_o high 1 cycle.
- Single bit, ready=1: map=0x0001, delta1[0]=100, delta2[0]=200 -> pkt_valid_o at capture+2 with idx 0, 100/200, pkt_last_o=1; frame_done_o next cycle; cnt=1.
- Sparse with backpressure: map=0x8421, ready low 5 cycles per packet -> packets idx 0,5,10,15 in order, fields stable while stalled, pkt_last_o only on idx 15, cnt=4.
- Full frame: map=0xFFFF, delta1[k]=k+1, ready=1 -> 16 packets idx 0..15; with RECV_EXCEED_SUM_EN, sum_delta1_o=136 at frame_done_o.
- Drop: second frame_valid_i while in EMIT -> frame_drop_o pulses 1 cycle, first frame output unchanged, next IDLE strobe captured normally.
- Reset mid-frame: rstn low while EMIT with map=0x00F0 -> all outputs 0 immediately, busy_o=0; a new frame after release is processed from idx 0.

Source files
------------

// File: rtl/recv_exceed_abs_pack.sv
// recv_exceed_abs_pack
// Consumer of the exceed-map interface from the delta threshold/abs stage.
// Captures one frame on each frame_valid_i strobe: a 16-bit exceed map and two
// arrays of 16 unsigned |delta| entries. It then walks the flagged indices in
// ascending order and emits one valid/ready packet per flagged entry.
//
// Optional feature: define RECV_EXCEED_SUM_EN to add sum_delta1_o. This output
// accumulates pkt_delta1_o over the accepted packets of the current frame.
//
// Ports:
//   clk, rstn            clock; asynchronous active-low reset
//   frame_valid_i        one-cycle capture strobe (honoured only in IDLE)
//   exceed_map_i         bit k set -> entry k is emitted
//   delta1_abs_i/2       16 x INWIDTH_DELTA unsigned magnitudes
//   pkt_ready_i          downstream accepts the packet
//   pkt_valid_o          packet valid (only in EMIT)
//   pkt_idx_o            index of the emitted entry
//   pkt_delta1_o/2       magnitudes at pkt_idx_o
//   pkt_last_o           packet is the highest flagged index of the frame
//   exceed_cnt_o         popcount of the captured map, held until next capture
//   busy_o               high while the FSM is not IDLE
//   frame_done_o         high for the single DONE cycle
//   frame_drop_o         one-cycle pulse after a strobe that arrived while busy
//   sum_delta1_o         (RECV_EXCEED_SUM_EN only) sum of accepted delta1
module recv_exceed_abs_pack #(
  parameter int INWIDTH_DELTA = 17
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          frame_valid_i,
  input  logic [15:0]                   exceed_map_i,
  input  logic [15:0][INWIDTH_DELTA-1:0] delta1_abs_i,
  input  logic [15:0][INWIDTH_DELTA-1:0] delta2_abs_i,
  input  logic                          pkt_ready_i,
  output logic                          pkt_valid_o,
  output logic [3:0]                    pkt_idx_o,
  output logic [INWIDTH_DELTA-1:0]      pkt_delta1_o,
  output logic [INWIDTH_DELTA-1:0]      pkt_delta2_o,
  output logic                          pkt_last_o,
  output logic [4:0]                    exceed_cnt_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          frame_drop_o
`ifdef RECV_EXCEED_SUM_EN
  ,
  output logic [INWIDTH_DELTA+3:0]      sum_delta1_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                           state;
  logic [15:0]                      map_r;
  logic [3:0]                       idx;
  logic [15:0][INWIDTH_DELTA-1:0]   d1_r;
  logic [15:0][INWIDTH_DELTA-1:0]   d2_r;

  // Number of set bits in a 16-bit map (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] c;
    c = 5'd0;
    for (int k = 0; k < 16; k++) begin
      c = c + {4'd0, m[k]};
    end
    return c;
  endfunction

  // True when no bit above position i is set. The shift amount is 5 bits wide
  // so that i=15 shifts everything out instead of wrapping to 0.
  function automatic logic is_last(input logic [15:0] m, input logic [3:0] i);
    logic [15:0] hi;
    hi = m >> ({1'b0, i} + 5'd1);
    return (hi == 16'd0);
  endfunction

  // Frame capture, index walk, packet handshake and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      map_r        <= 16'd0;
      idx          <= 4'd0;
      d1_r         <= '0;
      d2_r         <= '0;
      pkt_valid_o  <= 1'b0;
      pkt_idx_o    <= 4'd0;
      pkt_delta1_o <= '0;
      pkt_delta2_o <= '0;
      pkt_last_o   <= 1'b0;
      exceed_cnt_o <= 5'd0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_drop_o <= 1'b0;
`ifdef RECV_EXCEED_SUM_EN
      sum_delta1_o <= '0;
`endif
    end else begin
      // A strobe outside IDLE (including the DONE cycle) is reported and ignored.
      frame_drop_o <= frame_valid_i && (state != IDLE);

      case (state)
        IDLE: begin
          frame_done_o <= 1'b0;
          if (frame_valid_i) begin
            map_r        <= exceed_map_i;
            d1_r         <= delta1_abs_i;
            d2_r         <= delta2_abs_i;
            exceed_cnt_o <= popcount16(exceed_map_i);
            idx          <= 4'd0;
            busy_o       <= 1'b1;
`ifdef RECV_EXCEED_SUM_EN
            sum_delta1_o <= '0;
`endif
            if (exceed_map_i == 16'd0) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end else begin
            busy_o <= 1'b0;
          end
        end

        SCAN: begin
          // A set bit always remains ahead of idx, so the walk cannot pass 15.
          if (map_r[idx]) begin
            pkt_valid_o  <= 1'b1;
            pkt_idx_o    <= idx;
            pkt_delta1_o <= d1_r[idx];
            pkt_delta2_o <= d2_r[idx];
            pkt_last_o   <= is_last(map_r, idx);
            state        <= EMIT;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        EMIT: begin
          if (pkt_ready_i) begin
            pkt_valid_o <= 1'b0;
            map_r[idx]  <= 1'b0;
`ifdef RECV_EXCEED_SUM_EN
            sum_delta1_o <= sum_delta1_o + {4'd0, pkt_delta1_o};
`endif
            if (pkt_last_o) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
            end else begin
              idx   <= idx + 4'd1;
              state <= SCAN;
            end
          end else begin
            pkt_valid_o <= 1'b1;
          end
        end

        DONE: begin
          frame_done_o <= 1'b0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state        <= IDLE;
          pkt_valid_o  <= 1'b0;
          busy_o       <= 1'b0;
          frame_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recv_exceed_abs_pack.sv
// Directed self-checking bench for recv_exceed_abs_pack.
module tb_recv_exceed_abs_pack;
  localparam int W = 17;

  logic                clk;
  logic                rstn;
  logic                frame_valid_i;
  logic [15:0]         exceed_map_i;
  logic [15:0][W-1:0]  delta1_abs_i;
  logic [15:0][W-1:0]  delta2_abs_i;
  logic                pkt_ready_i;
  logic                pkt_valid_o;
  logic [3:0]          pkt_idx_o;
  logic [W-1:0]        pkt_delta1_o;
  logic [W-1:0]        pkt_delta2_o;
  logic                pkt_last_o;
  logic [4:0]          exceed_cnt_o;
  logic                busy_o;
  logic                frame_done_o;
  logic                frame_drop_o;
`ifdef RECV_EXCEED_SUM_EN
  logic [W+3:0]        sum_delta1_o;
`endif

  int checks = 0;
  int errors = 0;

  recv_exceed_abs_pack #(.INWIDTH_DELTA(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .frame_valid_i(frame_valid_i),
    .exceed_map_i (exceed_map_i),
    .delta1_abs_i (delta1_abs_i),
    .delta2_abs_i (delta2_abs_i),
    .pkt_ready_i  (pkt_ready_i),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_idx_o    (pkt_idx_o),
    .pkt_delta1_o (pkt_delta1_o),
    .pkt_delta2_o (pkt_delta2_o),
    .pkt_last_o   (pkt_last_o),
    .exceed_cnt_o (exceed_cnt_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .frame_drop_o (frame_drop_o)
`ifdef RECV_EXCEED_SUM_EN
    ,
    .sum_delta1_o (sum_delta1_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step until pkt_valid_o rises or the cycle budget expires.
  task automatic wait_valid(input string tag);
    for (int t = 0; t < 40 && pkt_valid_o !== 1'b1; t++) step();
    chk(tag, 32'(pkt_valid_o), 32'd1);
  endtask

  task automatic capture(input logic [15:0] m);
    exceed_map_i  = m;
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_idx [4];
    exp_idx[0] = 16'd0; exp_idx[1] = 16'd5; exp_idx[2] = 16'd10; exp_idx[3] = 16'd15;

    rstn = 1'b0; frame_valid_i = 1'b0; exceed_map_i = 16'd0;
    delta1_abs_i = '0; delta2_abs_i = '0; pkt_ready_i = 1'b0;
    step(); step();
    chk("rst_valid", 32'(pkt_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_done",  32'(frame_done_o), 32'd0);
    chk("rst_cnt",   32'(exceed_cnt_o), 32'd0);
    rstn = 1'b1;
    step();

    // Empty frame: DONE one cycle after capture, busy only that cycle.
    capture(16'h0000);
    chk("empty_done", 32'(frame_done_o), 32'd1);
    chk("empty_busy", 32'(busy_o),       32'd1);
    chk("empty_cnt",  32'(exceed_cnt_o), 32'd0);
    chk("empty_valid", 32'(pkt_valid_o), 32'd0);
    step();
    chk("empty_done_off", 32'(frame_done_o), 32'd0);
    chk("empty_busy_off", 32'(busy_o),       32'd0);

    // Single bit, ready high: valid at capture+2, accept next edge, then done.
    delta1_abs_i[0] = 17'd100; delta2_abs_i[0] = 17'd200; pkt_ready_i = 1'b1;
    capture(16'h0001);
    chk("single_scan_valid", 32'(pkt_valid_o), 32'd0);
    step();
    chk("single_valid", 32'(pkt_valid_o),  32'd1);
    chk("single_idx",   32'(pkt_idx_o),    32'd0);
    chk("single_d1",    32'(pkt_delta1_o), 32'd100);
    chk("single_d2",    32'(pkt_delta2_o), 32'd200);
    chk("single_last",  32'(pkt_last_o),   32'd1);
    chk("single_cnt",   32'(exceed_cnt_o), 32'd1);
    step();
    chk("single_valid_off", 32'(pkt_valid_o),  32'd0);
    chk("single_done",      32'(frame_done_o), 32'd1);
    step();

    // Sparse map with 5 cycles of backpressure per packet.
    for (int k = 0; k < 16; k++) begin
      delta1_abs_i[k] = 17'(1000 + k);
      delta2_abs_i[k] = 17'(70000 + k);
    end
    pkt_ready_i = 1'b0;
    capture(16'h8421);
    chk("sparse_cnt", 32'(exceed_cnt_o), 32'd4);
    for (int p = 0; p < 4; p++) begin
      wait_valid("sparse_valid");
      chk("sparse_idx",  32'(pkt_idx_o),    32'(exp_idx[p]));
      chk("sparse_d1",   32'(pkt_delta1_o), 32'(1000 + exp_idx[p]));
      chk("sparse_d2",   32'(pkt_delta2_o), 32'(70000 + exp_idx[p]));
      chk("sparse_last", 32'(pkt_last_o),   32'(p == 3));
      for (int s = 0; s < 5; s++) begin
        step();
        chk("sparse_hold_valid", 32'(pkt_valid_o),  32'd1);
        chk("sparse_hold_idx",   32'(pkt_idx_o),    32'(exp_idx[p]));
        chk("sparse_hold_d1",    32'(pkt_delta1_o), 32'(1000 + exp_idx[p]));
      end
      pkt_ready_i = 1'b1;
      step();
      pkt_ready_i = 1'b0;
      chk("sparse_after_accept", 32'(pkt_valid_o), 32'd0);
    end
    chk("sparse_done", 32'(frame_done_o), 32'd1);
    step();

    // Full map, delta1[k]=k+1, ready held high.
    for (int k = 0; k < 16; k++) delta1_abs_i[k] = 17'(k + 1);
    pkt_ready_i = 1'b1;
    capture(16'hFFFF);
    chk("full_cnt", 32'(exceed_cnt_o), 32'd16);
    for (int k = 0; k < 16; k++) begin
      wait_valid("full_valid");
      chk("full_idx",  32'(pkt_idx_o),    32'(k));
      chk("full_d1",   32'(pkt_delta1_o), 32'(k + 1));
      chk("full_last", 32'(pkt_last_o),   32'(k == 15));
      step();
    end
    chk("full_done", 32'(frame_done_o), 32'd1);
`ifdef RECV_EXCEED_SUM_EN
    chk("full_sum", 32'(sum_delta1_o), 32'd136);
`endif
    step();

    // Drop: strobe during EMIT is ignored and reported.
    pkt_ready_i = 1'b0;
    capture(16'h0004);
    wait_valid("drop_first_valid");
    capture(16'hFFFF);
    chk("drop_pulse", 32'(frame_drop_o), 32'd1);
    chk("drop_idx",   32'(pkt_idx_o),    32'd2);
    chk("drop_cnt",   32'(exceed_cnt_o), 32'd1);
    chk("drop_valid", 32'(pkt_valid_o),  32'd1);
    step();
    chk("drop_pulse_off", 32'(frame_drop_o), 32'd0);
    pkt_ready_i = 1'b1;
    step();
    chk("drop_done", 32'(frame_done_o), 32'd1);
    step();
    capture(16'h0002);
    step(); step();
    chk("drop_next_valid", 32'(pkt_valid_o),  32'd1);
    chk("drop_next_idx",   32'(pkt_idx_o),    32'd1);
    chk("drop_next_cnt",   32'(exceed_cnt_o), 32'd1);
    step(); step();

    // Reset in the middle of EMIT.
    pkt_ready_i = 1'b0;
    capture(16'h00F0);
    wait_valid("rstmid_valid");
    chk("rstmid_idx", 32'(pkt_idx_o), 32'd4);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstmid_valid_off", 32'(pkt_valid_o),  32'd0);
    chk("rstmid_busy",      32'(busy_o),       32'd0);
    chk("rstmid_cnt",       32'(exceed_cnt_o), 32'd0);
    chk("rstmid_idx_zero",  32'(pkt_idx_o),    32'd0);
    step();
    rstn = 1'b1;
    step();
    capture(16'h0008);
    wait_valid("rstmid_new_valid");
    chk("rstmid_new_idx",  32'(pkt_idx_o),    32'd3);
    chk("rstmid_new_last", 32'(pkt_last_o),   32'd1);
    chk("rstmid_new_cnt",  32'(exceed_cnt_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
